// File: rtl/arb_client.sv
// Requester-side client: queues jobs in a small FIFO, requests the 2-way arbiter and streams one beat per granted cycle.
// Latency: req rises one cycle after a job lands in an idle FIFO; beats follow the cycle after gnt is seen in REQ.
// Backpressure: job_ready drops when the FIFO is full; gnt low pauses beats in XFER; grant timeout in REQ drops the head job.
module arb_client #(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  input  logic             gnt,
  output logic             req,
  output logic             beat_valid,
  output logic             beat_last,
  output logic [LEN_W-1:0] beat_idx,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clr
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   mem_q [DEPTH];
  logic [LEN_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic               req_q, req_d;
  logic               err_q, err_d;

  logic               push;
  logic               pop;
  logic               set_err;
  logic               fifo_empty;
  logic [LEN_W-1:0]   head_len;

  // Job FIFO: ready depends only on occupancy, so a same-cycle pop never frees a slot for a push.
  always_comb begin
    job_ready  = (count_q != CNT_W'(DEPTH));
    fifo_empty = (count_q == '0);
    push       = job_valid && job_ready;
    head_len   = mem_q[rd_ptr_q];
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = job_len;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Request FSM: next state, counters, beat outputs and head-of-queue pops.
  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    beat_d     = '0;
    pop        = 1'b0;
    set_err    = 1'b0;
    beat_valid = 1'b0;
    beat_last  = 1'b0;
    beat_idx   = '0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (gnt) begin
          state_d = S_XFER;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          pop     = 1'b1;
          set_err = 1'b1;
          state_d = S_HOLD;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_XFER: begin
        beat_idx = beat_q;
        beat_d   = beat_q;
        if (gnt) begin
          beat_valid = 1'b1;
          if (beat_q == head_len) begin
            // Counter returns to zero here, so an all-ones length never wraps mid-job.
            beat_last = 1'b1;
            pop       = 1'b1;
            beat_d    = '0;
            state_d   = S_HOLD;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_d = (state_d == S_REQ) || (state_d == S_XFER);
    err_d = set_err || (err_q && !err_clr);
  end

  // State registers; reset empties the queue and drops req without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      beat_q   <= '0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      beat_q   <= beat_d;
      req_q    <= req_d;
      err_q    <= err_d;
      mem_q    <= mem_d;
    end
  end

  // Status outputs.
  always_comb begin
    req         = req_q;
    timeout_err = err_q;
    busy        = (state_q != S_IDLE) || !fifo_empty;
  end

endmodule

// File: tb/tb_arb_client.sv
// Directed bench for arb_client with default parameters (DEPTH=4, LEN_W=4, TIMEOUT=64).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Covers reset, single job, gnt pause, push+pop, full FIFO, timeout, reset mid-transfer, max length.
module tb_arb_client;

  logic       clk;
  logic       rst_n;
  logic       job_valid;
  logic [3:0] job_len;
  logic       job_ready;
  logic       gnt;
  logic       req;
  logic       beat_valid;
  logic       beat_last;
  logic [3:0] beat_idx;
  logic       busy;
  logic       timeout_err;
  logic       err_clr;

  int unsigned n_vec;
  int unsigned n_err;

  arb_client #(.DEPTH(4), .LEN_W(4), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .job_valid  (job_valid),
    .job_len    (job_len),
    .job_ready  (job_ready),
    .gnt        (gnt),
    .req        (req),
    .beat_valid (beat_valid),
    .beat_last  (beat_last),
    .beat_idx   (beat_idx),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_err);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One cycle: drive after the edge, check at the falling edge.
  task automatic cyc(input logic jv, input logic [3:0] len, input logic g,
                     input logic e_req, input logic e_bv, input logic [3:0] e_idx,
                     input logic e_last, input logic e_busy);
    @(posedge clk); #1;
    job_valid = jv;
    job_len   = len;
    gnt       = g;
    @(negedge clk);
    chk("req", 32'(req), 32'(e_req));
    chk("beat_valid", 32'(beat_valid), 32'(e_bv));
    chk("beat_idx", 32'(beat_idx), 32'(e_idx));
    chk("beat_last", 32'(beat_last), 32'(e_last));
    chk("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic push(input logic [3:0] len);
    @(posedge clk); #1;
    job_valid = 1'b1;
    job_len   = len;
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  // Collect one job's beats: indices must run 0..len with beat_last only on the final one.
  task automatic expect_beats(input int len);
    int  n;
    logic done;
    n    = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (beat_valid) begin
        chk("beat_idx_seq", 32'(beat_idx), 32'(n[3:0]));
        chk("beat_last_seq", 32'(beat_last), 32'(n == len));
        if (beat_last) done = 1'b1;
        n++;
      end
    end
    chk("beat_count", 32'(n), 32'(len + 1));
  endtask

  // Watch a job that never gets a grant until req drops.
  task automatic wait_drop(output int rq, output int early, output int beats);
    logic done;
    rq    = 0;
    early = 0;
    beats = 0;
    done  = 1'b0;
    for (int c = 0; c < 150 && !done; c++) begin
      @(negedge clk);
      if (beat_valid) beats++;
      if (req) begin
        rq++;
        if (timeout_err) early++;
      end else if (rq > 0) begin
        done = 1'b1;
      end
    end
  endtask

  initial begin
    int   rq;
    int   early;
    int   beats;
    int   extra;
    logic found;
    logic [3:0] lens [4];

    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    job_valid = 1'b0;
    job_len   = '0;
    gnt       = 1'b0;
    err_clr   = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_job_ready", 32'(job_ready), 32'd1);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_beat_valid", 32'(beat_valid), 32'd0);
    chk("rst_beat_last", 32'(beat_last), 32'd0);
    chk("rst_beat_idx", 32'(beat_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Single len=2 job, gnt held high
    //   jv  len   g     req  bv   idx   last busy
    cyc(1, 4'd2, 1,    0,   0,   4'd0, 0,   0);
    cyc(0, 4'd0, 1,    0,   0,   4'd0, 0,   1);
    cyc(0, 4'd0, 1,    1,   0,   4'd0, 0,   1);
    cyc(0, 4'd0, 1,    1,   1,   4'd0, 0,   1);
    cyc(0, 4'd0, 1,    1,   1,   4'd1, 0,   1);
    cyc(0, 4'd0, 1,    1,   1,   4'd2, 1,   1);
    cyc(0, 4'd0, 1,    0,   0,   4'd0, 0,   1);
    cyc(0, 4'd0, 1,    0,   0,   4'd0, 0,   0);

    // len=3 with a 2-cycle gnt gap after beat 1; a len=0 job is pushed on the last beat
    cyc(1, 4'd3, 1,    0,   0,   4'd0, 0,   0);
    cyc(0, 4'd0, 1,    0,   0,   4'd0, 0,   1);
    cyc(0, 4'd0, 1,    1,   0,   4'd0, 0,   1);
    cyc(0, 4'd0, 1,    1,   1,   4'd0, 0,   1);
    cyc(0, 4'd0, 1,    1,   1,   4'd1, 0,   1);
    cyc(0, 4'd0, 0,    1,   0,   4'd2, 0,   1);
    cyc(0, 4'd0, 0,    1,   0,   4'd2, 0,   1);
    cyc(0, 4'd0, 1,    1,   1,   4'd2, 0,   1);
    cyc(1, 4'd0, 1,    1,   1,   4'd3, 1,   1);
    cyc(0, 4'd0, 1,    0,   0,   4'd0, 0,   1);
    cyc(0, 4'd0, 1,    0,   0,   4'd0, 0,   1);
    cyc(0, 4'd0, 1,    1,   0,   4'd0, 0,   1);
    cyc(0, 4'd0, 1,    1,   1,   4'd0, 1,   1);
    cyc(0, 4'd0, 1,    0,   0,   4'd0, 0,   1);
    cyc(0, 4'd0, 1,    0,   0,   4'd0, 0,   0);

    // Fill the FIFO with gnt low, offer a fifth job, then drain in order
    lens[0] = 4'd0;
    lens[1] = 4'd1;
    lens[2] = 4'd2;
    lens[3] = 4'd3;
    gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      job_valid = 1'b1;
      job_len   = lens[i];
    end
    @(posedge clk); #1;
    job_len = 4'd7;
    @(negedge clk);
    chk("full_job_ready", 32'(job_ready), 32'd0);
    @(posedge clk); #1;
    job_valid = 1'b0;
    gnt       = 1'b1;
    @(negedge clk);
    chk("full_still_full", 32'(job_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      expect_beats(int'(lens[i]));
      @(negedge clk);
      chk("drain_gap_req", 32'(req), 32'd0);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (beat_valid) extra++;
    end
    chk("drain_no_fifth", 32'(extra), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_job_ready", 32'(job_ready), 32'd1);

    // Grant never arrives: 64 REQ cycles then the job is dropped
    gnt = 1'b0;
    push(4'd1);
    wait_drop(rq, early, beats);
    chk("to_req_cycles", 32'(rq), 32'd64);
    chk("to_err_set", 32'(timeout_err), 32'd1);
    chk("to_err_early", 32'(early), 32'd0);
    chk("to_no_beats", 32'(beats), 32'd0);
    repeat (3) @(negedge clk);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_err_sticky", 32'(timeout_err), 32'd1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("to_err_clr", 32'(timeout_err), 32'd0);

    // Timeout while err_clr is held: set wins on that edge, clear takes over next edge
    err_clr = 1'b1;
    push(4'd0);
    wait_drop(rq, early, beats);
    chk("tc_req_cycles", 32'(rq), 32'd64);
    chk("tc_set_wins", 32'(timeout_err), 32'd1);
    @(negedge clk);
    chk("tc_cleared", 32'(timeout_err), 32'd0);
    @(posedge clk); #1 err_clr = 1'b0;

    // Reset during beat 1 of a len=5 job with two more jobs queued
    @(posedge clk); #1;
    job_valid = 1'b1;
    job_len   = 4'd5;
    @(posedge clk); #1 job_len = 4'd1;
    @(posedge clk); #1 job_len = 4'd2;
    @(posedge clk); #1;
    job_valid = 1'b0;
    gnt       = 1'b1;
    found     = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (beat_valid && beat_idx == 4'd1) found = 1'b1;
    end
    chk("rx_reached_beat1", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rx_req", 32'(req), 32'd0);
    chk("rx_job_ready", 32'(job_ready), 32'd1);
    chk("rx_busy", 32'(busy), 32'd0);
    chk("rx_beat_valid", 32'(beat_valid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (beat_valid || req) extra++;
    end
    chk("rx_quiet_after", 32'(extra), 32'd0);
    chk("rx_busy_after", 32'(busy), 32'd0);

    // Maximum length: 16 beats, no counter wrap
    push(4'd15);
    expect_beats(15);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (beat_valid) extra++;
    end
    chk("max_no_extra", 32'(extra), 32'd0);
    chk("max_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
